ps2_zx_keyboard: RTL and testbench

- Upstream stage of the I/O port decoder: converts a PS/2 keyboard stream into the 8x5 ZX Spectrum key matrix.
- Presents the 5-bit active-low column vector `kd` for the matrix rows selected by CPU address A15..A8.
- Also provides magic-key and reset-key requests.
- All logic on clk28.

---
 rtl/ps2_zx_keyboard.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_zx_keyboard.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard receiver and decoder feeding the 8x5 ZX Spectrum key matrix.
// Rows are read back through addr_hi as active-low column data on kd.
module ps2_zx_keyboard #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 28000
) (
   input  logic       clk28,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   input  logic [7:0] addr_hi,
   output logic [4:0] kd,
   output logic       key_magic,
   output logic       key_reset,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic [FW-1:0] flt_cnt;
   logic          clk_flt, fall, dat;
   state_t        state, state_nxt;
   logic [7:0]    sh;
   logic [2:0]    bit_cnt;
   logic          par, byte_ok, err_now, timeout, byte_valid;
   logic [TW-1:0] tcnt;

   logic             ext, brk;
   logic [2:0]       skip;
   logic [7:0][4:0]  phys, pressed;
   logic             lshift, rshift, ctrl, alt, del;
   logic [4:0]       comp;
   logic [4:0]       kd_nxt;
   logic [6:0]       km;

   assign dat = dat_sync[1];

   // Synchronisers and glitch filter; fall is a single-cycle strobe on a filtered 1->0.
   always_ff @(posedge clk28) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         flt_cnt  <= '0;
         clk_flt  <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         fall     <= 1'b0;
         if (clk_sync[1] == clk_flt) flt_cnt <= '0;
         else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_flt <= clk_sync[1];
            flt_cnt <= '0;
            fall    <= clk_flt;
         end else flt_cnt <= flt_cnt + 1'b1;
      end
   end

   assign timeout = (state != S_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   // Receiver: state register and frame datapath
   always_ff @(posedge clk28) begin
      if (rst) begin
         state      <= S_IDLE;
         sh         <= '0;
         bit_cnt    <= '0;
         par        <= 1'b0;
         tcnt       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_valid <= byte_ok;
         frame_err  <= err_now;
         if (fall || state == S_IDLE) tcnt <= '0;
         else                         tcnt <= tcnt + 1'b1;
         if (fall) begin
            case (state)
               S_IDLE: bit_cnt <= '0;
               S_DATA: begin
                  sh      <= {dat, sh[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               S_PAR:  par <= dat;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (timeout) state_nxt = S_IDLE;
      else if (fall) begin
         case (state)
            S_IDLE: if (!dat) state_nxt = S_DATA;
            S_DATA: if (bit_cnt == 3'd7) state_nxt = S_PAR;
            S_PAR:  state_nxt = S_STOP;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      byte_ok = fall && state == S_STOP && dat && (^{sh, par});
      err_now = timeout || (fall && state == S_STOP && !(dat && (^{sh, par})));
   end

   // {hit, row, col} for keys that sit directly in the matrix
   function automatic logic [6:0] keymap(input logic [8:0] c);
      case (c)
         9'h01A: keymap = {1'b1, 3'd0, 3'd1};  9'h022: keymap = {1'b1, 3'd0, 3'd2};
         9'h021: keymap = {1'b1, 3'd0, 3'd3};  9'h02A: keymap = {1'b1, 3'd0, 3'd4};
         9'h01C: keymap = {1'b1, 3'd1, 3'd0};  9'h01B: keymap = {1'b1, 3'd1, 3'd1};
         9'h023: keymap = {1'b1, 3'd1, 3'd2};  9'h02B: keymap = {1'b1, 3'd1, 3'd3};
         9'h034: keymap = {1'b1, 3'd1, 3'd4};
         9'h015: keymap = {1'b1, 3'd2, 3'd0};  9'h01D: keymap = {1'b1, 3'd2, 3'd1};
         9'h024: keymap = {1'b1, 3'd2, 3'd2};  9'h02D: keymap = {1'b1, 3'd2, 3'd3};
         9'h02C: keymap = {1'b1, 3'd2, 3'd4};
         9'h016: keymap = {1'b1, 3'd3, 3'd0};  9'h01E: keymap = {1'b1, 3'd3, 3'd1};
         9'h026: keymap = {1'b1, 3'd3, 3'd2};  9'h025: keymap = {1'b1, 3'd3, 3'd3};
         9'h02E: keymap = {1'b1, 3'd3, 3'd4};
         9'h045: keymap = {1'b1, 3'd4, 3'd0};  9'h046: keymap = {1'b1, 3'd4, 3'd1};
         9'h03E: keymap = {1'b1, 3'd4, 3'd2};  9'h03D: keymap = {1'b1, 3'd4, 3'd3};
         9'h036: keymap = {1'b1, 3'd4, 3'd4};
         9'h04D: keymap = {1'b1, 3'd5, 3'd0};  9'h044: keymap = {1'b1, 3'd5, 3'd1};
         9'h043: keymap = {1'b1, 3'd5, 3'd2};  9'h03C: keymap = {1'b1, 3'd5, 3'd3};
         9'h035: keymap = {1'b1, 3'd5, 3'd4};
         9'h05A, 9'h15A: keymap = {1'b1, 3'd6, 3'd0};
         9'h04B: keymap = {1'b1, 3'd6, 3'd1};  9'h042: keymap = {1'b1, 3'd6, 3'd2};
         9'h03B: keymap = {1'b1, 3'd6, 3'd3};  9'h033: keymap = {1'b1, 3'd6, 3'd4};
         9'h029: keymap = {1'b1, 3'd7, 3'd0};
         9'h014, 9'h114: keymap = {1'b1, 3'd7, 3'd1};
         9'h03A: keymap = {1'b1, 3'd7, 3'd2};  9'h031: keymap = {1'b1, 3'd7, 3'd3};
         9'h032: keymap = {1'b1, 3'd7, 3'd4};
         default: keymap = '0;
      endcase
   endfunction

   assign km = keymap({ext, sh});

   // Composite keys keep their own bits so releasing one never drops a physical key.
   always_comb begin
      pressed       = phys;
      pressed[0][0] = lshift | rshift | (|comp);
      pressed[4][0] = phys[4][0] | comp[0];
      pressed[3][4] = phys[3][4] | comp[1];
      pressed[4][4] = phys[4][4] | comp[2];
      pressed[4][3] = phys[4][3] | comp[3];
      pressed[4][2] = phys[4][2] | comp[4];
      kd_nxt = 5'b11111;
      for (int r = 0; r < 8; r++)
         if (!addr_hi[r]) kd_nxt = kd_nxt & ~pressed[r];
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         ext <= 1'b0; brk <= 1'b0; skip <= '0;
         phys <= '0; lshift <= 1'b0; rshift <= 1'b0; comp <= '0;
         ctrl <= 1'b0; alt <= 1'b0; del <= 1'b0;
         kd <= 5'b11111; key_magic <= 1'b0; key_reset <= 1'b0;
      end else begin
         kd        <= kd_nxt;
         key_reset <= ctrl & alt & del;
         key_magic <= 1'b0;
         if (byte_valid) begin
            if (skip != 3'd0) skip <= skip - 1'b1;
            else if (sh == 8'hE1) begin
               skip <= 3'd7;
               ext  <= 1'b0;
               brk  <= 1'b0;
            end
            else if (sh == 8'hE0) ext <= 1'b1;
            else if (sh == 8'hF0) brk <= 1'b1;
            else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (km[6]) phys[km[5:3]][km[2:0]] <= !brk;
               case ({ext, sh})
                  9'h012:          lshift    <= !brk;
                  9'h059:          rshift    <= !brk;
                  9'h066:          comp[0]   <= !brk;
                  9'h16B:          comp[1]   <= !brk;
                  9'h172:          comp[2]   <= !brk;
                  9'h175:          comp[3]   <= !brk;
                  9'h174:          comp[4]   <= !brk;
                  9'h014, 9'h114:  ctrl      <= !brk;
                  9'h011, 9'h111:  alt       <= !brk;
                  9'h171:          del       <= !brk;
                  9'h007:          key_magic <= !brk;
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Directed bench for ps2_zx_keyboard: table of byte/row-read vectors plus hand sequences.
module tb_ps2_zx_keyboard;
   logic       clk28 = 1'b0;
   logic       rst, ps2_clk, ps2_dat;
   logic [7:0] addr_hi;
   logic [4:0] kd;
   logic       key_magic, key_reset, frame_err;

   int total = 0, passed = 0;
   int err_cnt = 0, mag_cnt = 0;

   typedef struct {
      bit         send;
      logic [7:0] code;
      logic [7:0] addr;
      logic [4:0] exp_kd;
   } vec_t;

   vec_t vecs[$];

   ps2_zx_keyboard dut (
      .clk28(clk28), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .addr_hi(addr_hi), .kd(kd), .key_magic(key_magic),
      .key_reset(key_reset), .frame_err(frame_err)
   );

   always #18 clk28 = ~clk28;

   always @(negedge clk28) begin
      if (frame_err) err_cnt++;
      if (key_magic) mag_cnt++;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_dat = bits[i];
         repeat (20) @(negedge clk28);
         ps2_clk = 1'b0;
         repeat (20) @(negedge clk28);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0);
      logic p;
      p = ~(^b) ^ bad_par;
      send_bits({1'b1, p, b, 1'b0}, 11);
      ps2_dat = 1'b1;
      repeat (40) @(negedge clk28);
   endtask

   task automatic read_row(input string name, input logic [7:0] a, input logic [4:0] e);
      addr_hi = a;
      repeat (2) @(negedge clk28);
      check(name, {3'b000, kd}, {3'b000, e});
   endtask

   task automatic add(input bit s, input logic [7:0] c, input logic [7:0] a, input logic [4:0] e);
      vec_t v;
      v.send = s; v.code = c; v.addr = a; v.exp_kd = e;
      vecs.push_back(v);
   endtask

   initial begin
      int e0, m0;
      // Make/break and multi-row reads
      add(1, 8'h1C, 8'hFD, 5'b11110); add(1, 8'hF0, 8'hFD, 5'b11110);
      add(1, 8'h1C, 8'hFD, 5'b11111);
      add(1, 8'h1A, 8'hFE, 5'b11101); add(1, 8'h1B, 8'hFC, 5'b11101);
      add(0, 8'h00, 8'hFE, 5'b11101); add(0, 8'h00, 8'hFD, 5'b11101);
      add(0, 8'h00, 8'hFF, 5'b11111);
      add(1, 8'hF0, 8'hFE, 5'b11101); add(1, 8'h1A, 8'hFE, 5'b11111);
      add(1, 8'hF0, 8'hFD, 5'b11101); add(1, 8'h1B, 8'hFD, 5'b11111);
      // Composite CS+5 overlapping with a held shift
      add(1, 8'hE0, 8'hFE, 5'b11111); add(1, 8'h6B, 8'hFE, 5'b11110);
      add(0, 8'h00, 8'hF7, 5'b01111);
      add(1, 8'h12, 8'hFE, 5'b11110); add(1, 8'hE0, 8'hFE, 5'b11110);
      add(1, 8'hF0, 8'hFE, 5'b11110); add(1, 8'h6B, 8'hFE, 5'b11110);
      add(0, 8'h00, 8'hF7, 5'b11111);
      add(1, 8'hF0, 8'hFE, 5'b11110); add(1, 8'h12, 8'hFE, 5'b11111);
      // Backspace release must not drop a held physical 0
      add(1, 8'h45, 8'hEF, 5'b11110); add(1, 8'h66, 8'hEF, 5'b11110);
      add(0, 8'h00, 8'hFE, 5'b11110);
      add(1, 8'hF0, 8'hEF, 5'b11110); add(1, 8'h66, 8'hEF, 5'b11110);
      add(0, 8'h00, 8'hFE, 5'b11111);
      add(1, 8'hF0, 8'hEF, 5'b11110); add(1, 8'h45, 8'hEF, 5'b11111);
      // Pause sequence is swallowed whole (its 14 must not press SS)
      add(1, 8'hE1, 8'h7F, 5'b11111); add(1, 8'h14, 8'h7F, 5'b11111);
      add(1, 8'h77, 8'h7F, 5'b11111); add(1, 8'hE1, 8'h7F, 5'b11111);
      add(1, 8'hF0, 8'h7F, 5'b11111); add(1, 8'h14, 8'h7F, 5'b11111);
      add(1, 8'hF0, 8'h7F, 5'b11111); add(1, 8'h77, 8'h7F, 5'b11111);
      add(1, 8'h1C, 8'hFD, 5'b11110); add(0, 8'h00, 8'h7F, 5'b11111);
      add(1, 8'hF0, 8'hFD, 5'b11110); add(1, 8'h1C, 8'hFD, 5'b11111);
      // Extended Enter, Space, break-then-make in consecutive bytes
      add(1, 8'hE0, 8'hBF, 5'b11111); add(1, 8'h5A, 8'hBF, 5'b11110);
      add(1, 8'h29, 8'h7F, 5'b11110); add(0, 8'h00, 8'h3F, 5'b11110);
      add(1, 8'hF0, 8'h7F, 5'b11110); add(1, 8'h29, 8'h7F, 5'b11111);
      add(1, 8'h29, 8'h7F, 5'b11110);

      rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; addr_hi = 8'h00;
      repeat (3) @(negedge clk28);
      check("rst_kd", {3'b000, kd}, 8'h1F);
      check("rst_magic", {7'b0, key_magic}, 8'h00);
      check("rst_reset", {7'b0, key_reset}, 8'h00);
      check("rst_err", {7'b0, frame_err}, 8'h00);
      rst = 1'b0;
      repeat (5) @(negedge clk28);

      foreach (vecs[i]) begin
         if (vecs[i].send) send_byte(vecs[i].code);
         read_row($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_kd);
      end

      // One-cycle read latency after an address change
      send_byte(8'h1C);
      addr_hi = 8'hFF;
      repeat (2) @(negedge clk28);
      addr_hi = 8'hFD;
      @(negedge clk28);
      check("addr_lat", {3'b000, kd}, 8'h1E);
      send_byte(8'hF0); send_byte(8'h1C);

      // Ctrl+Alt+Del
      send_byte(8'h14); send_byte(8'h11); send_byte(8'hE0); send_byte(8'h71);
      check("reset_on", {7'b0, key_reset}, 8'h01);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h71);
      check("reset_off", {7'b0, key_reset}, 8'h00);
      send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h11);

      // F12 magic pulse
      m0 = mag_cnt;
      send_byte(8'h07);
      check("magic_make", 8'(mag_cnt - m0), 8'h01);
      m0 = mag_cnt;
      send_byte(8'hF0); send_byte(8'h07);
      check("magic_break", 8'(mag_cnt - m0), 8'h00);

      // Bad parity
      e0 = err_cnt;
      send_byte(8'h1C, 1'b1);
      check("par_err", 8'(err_cnt - e0), 8'h01);
      read_row("par_nochg", 8'hFD, 5'b11111);

      // Partial frame then timeout, then a clean byte
      e0 = err_cnt;
      send_bits({3'b111, 8'h16 ^ 8'h0F}, 5);
      ps2_dat = 1'b1;
      repeat (28100) @(negedge clk28);
      check("timeout_err", 8'(err_cnt - e0), 8'h01);
      send_byte(8'h16);
      read_row("after_to", 8'hF7, 5'b11110);

      // Reset in the middle of a frame
      e0 = err_cnt;
      send_bits({2'b11, ~(^8'h29), 8'h29, 1'b0}, 4);
      rst = 1'b1;
      repeat (2) @(negedge clk28);
      rst = 1'b0;
      ps2_dat = 1'b1;
      repeat (5) @(negedge clk28);
      read_row("rst_clear", 8'h00, 5'b11111);
      send_byte(8'h29);
      read_row("rst_space", 8'h7F, 5'b11110);
      repeat (30000) @(negedge clk28);
      check("rst_noerr", 8'(err_cnt - e0), 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
